// File: rtl/rv_decode_pkg.sv
// Shared opcode constants, instruction-format enum and XLEN legality helper
// for the RISC-V decode stage.
package rv_decode_pkg;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_REG      = 7'b0110011;
  localparam logic [6:0] OP_IMM_32   = 7'b0011011;
  localparam logic [6:0] OP_REG_32   = 7'b0111011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/instr_imm_gen.sv
// Combinational format classification and sign-extended immediate generation.
// DECODE_ILLEGAL_EN adds the illegal-instruction check; otherwise illegal is 0.
module instr_imm_gen
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output fmt_e            fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [6:0]  opcode;
  logic [31:0] imm32;

  assign opcode = instr[6:0];

  always_comb begin
    fmt = FMT_R;
    case (opcode)
      OP_LUI, OP_AUIPC:                                  fmt = FMT_U;
      OP_JAL:                                            fmt = FMT_J;
      OP_JALR, OP_LOAD, OP_IMM, OP_MISC_MEM, OP_SYSTEM:  fmt = FMT_I;
      OP_BRANCH:                                         fmt = FMT_B;
      OP_STORE:                                          fmt = FMT_S;
      OP_IMM_32:                                         fmt = (XLEN == 64) ? FMT_I : FMT_R;
      default:                                           fmt = FMT_R;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

`ifdef DECODE_ILLEGAL_EN
  // Unmapped opcodes classify as R, so R with a non-register opcode means unknown.
  logic reg_op;
  logic bad_funct7;
  assign reg_op     = (opcode == OP_REG) || ((XLEN == 64) && (opcode == OP_REG_32));
  assign bad_funct7 = (opcode == OP_REG) &&
                      !(instr[31:25] inside {7'b0000000, 7'b0100000, 7'b0000001});
  assign illegal    = (instr[1:0] != 2'b11) || (instr == 32'd0) ||
                      ((fmt == FMT_R) && !reg_op) || bad_funct7;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: rtl/instr_decode_stage.sv
// Registered RISC-V decode stage with valid/ready handshake and flush.
// Optional illegal-instruction detection is enabled by DECODE_ILLEGAL_EN.
module instr_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  generate
    if (!xlen_legal(XLEN)) begin : g_bad_xlen
      $error("instr_decode_stage: XLEN must be 32 or 64");
    end
  endgenerate

  fmt_e            dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic            accept;
  logic            load;

  instr_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr   (in_instr),
    .fmt     (dec_fmt),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // A flushed accept is dropped, so the data registers keep their old value.
  assign load     = accept && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           out_valid <= 1'b0;
    else if (flush)    out_valid <= 1'b0;
    else if (accept)   out_valid <= 1'b1;
    else if (out_ready) out_valid <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_pc      <= '0;
      out_opcode  <= '0;
      out_rd      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_funct3  <= '0;
      out_funct7  <= '0;
      out_fmt     <= FMT_R;
      out_imm     <= '0;
      out_illegal <= 1'b0;
    end else if (load) begin
      out_pc      <= in_pc;
      out_opcode  <= in_instr[6:0];
      out_rd      <= in_instr[11:7];
      out_rs1     <= in_instr[19:15];
      out_rs2     <= in_instr[24:20];
      out_funct3  <= in_instr[14:12];
      out_funct7  <= in_instr[31:25];
      out_fmt     <= dec_fmt;
      out_imm     <= dec_imm;
      out_illegal <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Randomized bench for instr_decode_stage: RV32 and RV64 instances share the
// same stimulus and are checked every cycle against a queue-based model.
module tb_instr_decode_stage;

  typedef struct packed {
    logic [63:0] pc;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic        ill;
  } dec_t;

`ifdef DECODE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic out_ready = 1'b1;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;

  logic rdy32, v32, ill32, rdy64, v64, ill64;
  logic [31:0] pc32, imm32;
  logic [63:0] pc64, imm64;
  logic [6:0]  op32, f7_32, op64, f7_64;
  logic [4:0]  rd32, rs1_32, rs2_32, rd64, rs1_64, rs2_64;
  logic [2:0]  f3_32, fmt32, f3_64, fmt64;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  logic [95:0] q[$];
  logic [6:0]  ops [0:12];

  always #5 clk = ~clk;

  instr_decode_stage #(.XLEN(32)) d32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr),
    .in_pc(in_pc[31:0]), .flush(flush), .out_valid(v32), .out_ready(out_ready),
    .out_pc(pc32), .out_opcode(op32), .out_rd(rd32), .out_rs1(rs1_32), .out_rs2(rs2_32),
    .out_funct3(f3_32), .out_funct7(f7_32), .out_fmt(fmt32), .out_imm(imm32),
    .out_illegal(ill32));

  instr_decode_stage #(.XLEN(64)) d64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(v64), .out_ready(out_ready),
    .out_pc(pc64), .out_opcode(op64), .out_rd(rd64), .out_rs1(rs1_64), .out_rs2(rs2_64),
    .out_funct3(f3_64), .out_funct7(f7_64), .out_fmt(fmt64), .out_imm(imm64),
    .out_illegal(ill64));

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Reference decode written from the ISA encoding rules with integer arithmetic.
  function automatic dec_t model(input logic [31:0] i, input logic [63:0] pc, input int xlen);
    dec_t d;
    int si, f, v;
    int b7, b20, f6, f4, f10, f8, rdv;
    bit known;
    longint s;
    d = '0;
    d.pc = (xlen == 64) ? pc : {32'b0, pc[31:0]};
    d.op = i[6:0]; d.rd = i[11:7]; d.rs1 = i[19:15]; d.rs2 = i[24:20];
    d.f3 = i[14:12]; d.f7 = i[31:25];
    si = i; b7 = i[7]; b20 = i[20]; f6 = i[30:25]; f4 = i[11:8];
    f10 = i[30:21]; f8 = i[19:12]; rdv = i[11:7];
    f = 0; known = 1'b1;
    case (int'(i[6:0]))
      55, 23:               f = 4;
      111:                  f = 5;
      103, 3, 19, 15, 115:  f = 1;
      99:                   f = 3;
      35:                   f = 2;
      51:                   f = 0;
      27:                   if (xlen == 64) f = 1; else known = 1'b0;
      59:                   if (xlen != 64) known = 1'b0;
      default:              known = 1'b0;
    endcase
    case (f)
      1:       v = si >>> 20;
      2:       v = (si >>> 25) * 32 + rdv;
      3:       v = (si >>> 31) * 4096 + b7 * 2048 + f6 * 32 + f4 * 2;
      4:       v = (si >>> 12) * 4096;
      5:       v = (si >>> 31) * 1048576 + f8 * 4096 + b20 * 2048 + f10 * 2;
      default: v = 0;
    endcase
    s = v;
    d.fmt = 3'(f);
    d.imm = (xlen == 64) ? s : {32'b0, s[31:0]};
    d.ill = ILL_EN && ((i[1:0] != 2'b11) || (i == 32'd0) || !known ||
            ((i[6:0] == 7'd51) && !((i[31:25] == 7'd0) || (i[31:25] == 7'd32) || (i[31:25] == 7'd1))));
    return d;
  endfunction

  function automatic dec_t act32();
    return '{pc: {32'b0, pc32}, op: op32, rd: rd32, rs1: rs1_32, rs2: rs2_32, f3: f3_32,
             f7: f7_32, fmt: fmt32, imm: {32'b0, imm32}, ill: ill32};
  endfunction

  function automatic dec_t act64();
    return '{pc: pc64, op: op64, rd: rd64, rs1: rs1_64, rs2: rs2_64, f3: f3_64,
             f7: f7_64, fmt: fmt64, imm: imm64, ill: ill64};
  endfunction

  // Model: at most one held instruction, tracked as a queue of {pc, instr}.
  always @(posedge clk or posedge rst) begin
    if (rst) q.delete();
    else begin
      bit acc;
      acc = in_valid && (q.size() == 0 || out_ready);
      if (flush) q.delete();
      else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (acc) q.push_back({in_pc, in_instr});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      bit er;
      er = (q.size() == 0) || out_ready;
      chk("in_ready32", rdy32, er);
      chk("in_ready64", rdy64, er);
      chk("out_valid32", v32, q.size() != 0);
      chk("out_valid64", v64, q.size() != 0);
      if (q.size() > 0) begin
        chk("dec32", act32(), model(q[0][31:0], q[0][95:32], 32));
        chk("dec64", act64(), model(q[0][31:0], q[0][95:32], 64));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                       input logic rdy, input logic fl);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl;
  endtask

  task automatic chk_reset_zero(input string tag);
    chk({tag, "_v"}, {v32, v64}, 2'b00);
    chk({tag, "_d32"}, act32(), '0);
    chk({tag, "_d64"}, act64(), '0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k < 7) r[6:0] = ops[$urandom_range(0, 12)];
    else if (k == 7) begin
      r[6:0] = 7'b0110011;
      case ($urandom_range(0, 2))
        0: r[31:25] = 7'b0000000;
        1: r[31:25] = 7'b0100000;
        default: r[31:25] = 7'b0000001;
      endcase
    end else if (k == 8) r = 32'd0;
    return r;
  endfunction

  initial begin
    ops[0] = 7'b0110111; ops[1] = 7'b0010111; ops[2] = 7'b1101111; ops[3] = 7'b1100111;
    ops[4] = 7'b0000011; ops[5] = 7'b0010011; ops[6] = 7'b0001111; ops[7] = 7'b1110011;
    ops[8] = 7'b1100011; ops[9] = 7'b0100011; ops[10] = 7'b0110011; ops[11] = 7'b0011011;
    ops[12] = 7'b0111011;

    #7;
    chk_reset_zero("reset");
    #5;
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {rdy32, rdy64}, 2'b11);

    // addi x1,x0,5
    drive(1, 32'h00500093, 64'h100, 1, 0);
    tick();
    drive(0, 32'h0, 64'h0, 1, 0);
    #2;
    chk("addi_valid", v32, 1'b1);
    chk("addi_rd", rd32, 5'd1);
    chk("addi_rs1", rs1_32, 5'd0);
    chk("addi_fmt", fmt32, 3'd1);
    chk("addi_imm", imm32, 32'd5);

    // sw x1,-4(x2)
    drive(1, 32'hFE112E23, 64'h104, 1, 0);
    tick();
    drive(0, 32'h0, 64'h0, 1, 0);
    #2;
    chk("sw_fmt", fmt64, 3'd2);
    chk("sw_rs1", rs1_64, 5'd2);
    chk("sw_rs2", rs2_64, 5'd1);
    chk("sw_f3", f3_64, 3'b010);
    chk("sw_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("sw_imm32", imm32, 32'hFFFF_FFFC);

    // lui then two more back to back
    drive(1, 32'h123452B7, 64'h200, 1, 0);
    tick();
    #2;
    chk("lui_fmt", fmt32, 3'd4);
    chk("lui_rd", rd32, 5'd5);
    chk("lui_imm", imm32, 32'h1234_5000);
    #7;
    drive(1, 32'h00500093, 64'h204, 1, 0);
    tick();
    drive(1, 32'hFE112E23, 64'h208, 1, 0);
    tick();
    drive(0, 32'h0, 64'h0, 1, 0);
    tick();

    // stall four cycles with a new instruction waiting
    drive(1, 32'h123452B7, 64'h300, 1, 0);
    tick();
    drive(1, 32'h00500093, 64'h304, 0, 0);
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("stall_ready", rdy32, 1'b0);
      chk("stall_hold_rd", rd64, 5'd5);
      chk("stall_hold_pc", pc64, 64'h300);
    end
    out_ready = 1'b1;
    #2;
    chk("release_ready", {rdy32, rdy64}, 2'b11);
    tick();
    drive(0, 32'h0, 64'h0, 1, 0);
    tick();

    // flush while stalled
    drive(1, 32'h123452B7, 64'h400, 1, 0);
    tick();
    drive(0, 32'h0, 64'h0, 0, 0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #2;
    chk("flush_stall_valid", {v32, v64}, 2'b00);

    // flush with a new instruction: dropped
    drive(1, 32'h00500093, 64'h500, 1, 1);
    tick();
    drive(0, 32'h0, 64'h0, 1, 0);
    #2;
    chk("flush_drop_valid", {v32, v64}, 2'b00);

    // all-zero word
    drive(1, 32'h0, 64'h600, 1, 0);
    tick();
    drive(0, 32'h0, 64'h0, 1, 0);
    #2;
    chk("zero_illegal", {ill32, ill64}, {ILL_EN, ILL_EN});
    chk("zero_fmt", fmt64, 3'd0);
    chk("zero_imm", imm64, 64'd0);

    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), {$urandom, $urandom},
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      tick();
    end

    // reset mid-stall
    drive(1, 32'h123452B7, 64'h700, 1, 0);
    tick();
    drive(0, 32'h0, 64'h0, 0, 0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_zero("midstall_reset");
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("ready_after_rst2", {rdy32, rdy64}, 2'b11);
    tick();
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
